// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the Basys3 seven-segment scan scheduler.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package sevenseg_pkg;

    localparam int unsigned BCD_DIGITS = 4;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StConv   = 2'd1,
        StCommit = 2'd2
    } conv_state_e;

    // Double-dabble correction step: bump every nibble >= 5 by 3 before the shift.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [4*BCD_DIGITS-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Codes above 9 cannot come out of the converter; they decode to all-off.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_scheduler.sv
// Sequential binary-to-BCD converter with a one-deep pending slot, an atomic display
// register, and a round-robin anode scanner with leading-zero blanking.
module sevenseg_scan_scheduler
    import sevenseg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned WIDTH        = 12,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             value_valid,
    input  logic             blank,
    output logic             busy,
    output logic [6:0]       SEG,
    output logic [3:0]       AN
);

    localparam int unsigned BcdW = 4 * BCD_DIGITS;
    localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    conv_state_e           state_q;
    logic [BcdW+WIDTH-1:0] conv_q;
    logic [BcdW+WIDTH-1:0] conv_adj;
    logic [3:0]            bit_q;
    logic                  busy_q;
    logic [BcdW-1:0]       disp_q;
    logic [WIDTH-1:0]      pend_q;
    logic                  pend_vld_q;

    logic                  can_start;
    logic                  start;
    logic [WIDTH-1:0]      start_val;

    logic [CntW-1:0]       refr_q;
    logic [1:0]            idx_q;
    logic [3:0]            an_q;
    logic [6:0]            seg_q;
    logic [3:0]            digit_on;
    logic [3:0]            sel_nib;
    logic [6:0]            seg_dec;

    // Upper BcdW bits of conv_q hold the BCD accumulator, lower WIDTH bits the operand.
    always_comb begin
        conv_adj  = {bcd_adjust(conv_q[BcdW+WIDTH-1:WIDTH]), conv_q[WIDTH-1:0]};
        // COMMIT may chain straight into the next conversion so back-to-back work has no gap.
        can_start = (state_q == StIdle) || (state_q == StCommit);
        start     = can_start && (pend_vld_q || value_valid);
        start_val = pend_vld_q ? pend_q : value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            conv_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StConv;
                        conv_q  <= {{BcdW{1'b0}}, start_val};
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StConv: begin
                    conv_q <= conv_adj << 1;
                    bit_q  <= bit_q + 4'd1;
                    if (bit_q == 4'(WIDTH - 1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    disp_q <= conv_q[BcdW+WIDTH-1:WIDTH];
                    if (start) begin
                        state_q <= StConv;
                        conv_q  <= {{BcdW{1'b0}}, start_val};
                        bit_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Latest strobe wins; a pending value handed to the converter frees the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (can_start && pend_vld_q) begin
            pend_q     <= value;
            pend_vld_q <= value_valid;
        end else if (!can_start && value_valid) begin
            pend_q     <= value;
            pend_vld_q <= 1'b1;
        end else if (can_start) begin
            pend_vld_q <= 1'b0;
        end
    end

    always_comb begin
        digit_on[0] = 1'b1;
        digit_on[1] = (LZ_BLANK == 0) || (disp_q[BcdW-1:4] != '0);
        digit_on[2] = (LZ_BLANK == 0) || (disp_q[BcdW-1:8] != '0);
        digit_on[3] = (LZ_BLANK == 0) || (disp_q[BcdW-1:12] != '0);
        sel_nib     = disp_q[{idx_q, 2'b00} +: 4];
    end

    sevenseg_decode u_decode (
        .bcd_i (sel_nib),
        .seg_o (seg_dec)
    );

    // AN and SEG are registered from the same index so they always switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            refr_q <= '0;
            idx_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
        end else begin
            if (refr_q == CntW'(DIGIT_CYCLES - 1)) begin
                refr_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                refr_q <= refr_q + CntW'(1);
            end
            if (blank || !digit_on[idx_q]) begin
                an_q  <= AN_OFF;
                seg_q <= SEG_OFF;
            end else begin
                an_q  <= ~(4'b0001 << idx_q);
                seg_q <= seg_dec;
            end
        end
    end

    assign busy = busy_q;
    assign SEG  = seg_q;
    assign AN   = an_q;

endmodule

// File: tb/tb_sevenseg_scan_scheduler.sv
// Directed self-checking bench for the seven-segment scan scheduler (DIGIT_CYCLES=4).
module tb_sevenseg_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] value = '0;
    logic        value_valid = 1'b0;
    logic        blank = 1'b0;
    logic        busy;
    logic [6:0]  SEG;
    logic [3:0]  AN;

    int checks = 0;
    int errors = 0;

    sevenseg_scan_scheduler #(
        .DIGIT_CYCLES (4),
        .WIDTH        (12),
        .LZ_BLANK     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .blank       (blank),
        .busy        (busy),
        .SEG         (SEG),
        .AN          (AN)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampling the first cycle of a digit-0 slot.
    task automatic wait_slot0(input string tag);
        int n;
        n = 0;
        while (AN === 4'b1110 && n < 40) begin tick(); n++; end
        while (AN !== 4'b1110 && n < 80) begin tick(); n++; end
        checks++;
        if (AN !== 4'b1110) begin
            errors++;
            $display("FAIL %s slot0_sync: AN=%b expected 1110", tag, AN);
        end
    endtask

    task automatic strobe(input logic [11:0] v);
        value       = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (AN !== 4'b1111 || SEG !== 7'b1111111 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: AN=%b SEG=%b busy=%b expected 1111 1111111 0", AN, SEG, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (AN !== 4'b1110 || SEG !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first_digit: AN=%b SEG=%b expected 1110 1000000", AN, SEG);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (AN[3:1] !== 3'b111 || (AN[0] === 1'b0 && SEG !== 7'b1000000)) begin
                errors++;
                $display("FAIL reset_zero_scan cyc %0d: AN=%b SEG=%b expected AN[3:1]=111 SEG=1000000", i, AN, SEG);
            end
            tick();
        end
    endtask

    task automatic test_scan_1234();
        logic [15:0] an_exp;
        logic [27:0] seg_exp;
        strobe(12'd1234);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (busy !== 1'b1 || dut.disp_q !== 16'h0000) begin
                errors++;
                $display("FAIL conv_1234 cyc %0d: busy=%b disp=%h expected 1 0000", i, busy, dut.disp_q);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b1 || dut.disp_q !== 16'h0000) begin
            errors++;
            $display("FAIL commit_cycle_1234: busy=%b disp=%h expected 1 0000", busy, dut.disp_q);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || dut.disp_q !== 16'h1234) begin
            errors++;
            $display("FAIL latency_1234: busy=%b disp=%h expected 0 1234", busy, dut.disp_q);
        end
        an_exp  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        seg_exp = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        wait_slot0("frame_1234");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (AN !== an_exp[4*k +: 4] || SEG !== seg_exp[7*k +: 7]) begin
                    errors++;
                    $display("FAIL frame_1234 slot %0d cyc %0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                             k, j, AN, SEG, an_exp[4*k +: 4], seg_exp[7*k +: 7]);
                end
                tick();
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] an_exp;
        logic [27:0] seg_exp;
        strobe(12'd7);
        for (int i = 0; i < 14; i++) tick();
        an_exp  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        seg_exp = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
        wait_slot0("frame_7");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (AN !== an_exp[4*k +: 4] || SEG !== seg_exp[7*k +: 7]) begin
                    errors++;
                    $display("FAIL frame_7 slot %0d cyc %0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                             k, j, AN, SEG, an_exp[4*k +: 4], seg_exp[7*k +: 7]);
                end
                tick();
            end
        end
        strobe(12'd4095);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (dut.disp_q !== 16'h4095) begin
            errors++;
            $display("FAIL disp_4095: disp=%h expected 4095", dut.disp_q);
        end
        an_exp  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        seg_exp = {7'b0011001, 7'b1000000, 7'b0010000, 7'b0010010};
        wait_slot0("frame_4095");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (AN !== an_exp[4*k +: 4] || SEG !== seg_exp[7*k +: 7]) begin
                    errors++;
                    $display("FAIL frame_4095 slot %0d cyc %0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                             k, j, AN, SEG, an_exp[4*k +: 4], seg_exp[7*k +: 7]);
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_disp;
        strobe(12'd100);
        strobe(12'd200);
        strobe(12'd300);
        // Sampling after edge 3 of the first conversion; 300 commits at edge 27.
        for (int n = 3; n <= 26; n++) begin
            exp_disp = (n < 14) ? 16'h4095 : 16'h0100;
            checks++;
            if (busy !== 1'b1 || dut.disp_q !== exp_disp) begin
                errors++;
                $display("FAIL b2b edge %0d: busy=%b disp=%h expected 1 %h", n, busy, dut.disp_q, exp_disp);
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b0 || dut.disp_q !== 16'h0300) begin
                errors++;
                $display("FAIL b2b_final cyc %0d: busy=%b disp=%h expected 0 0300", i, busy, dut.disp_q);
            end
            tick();
        end
    endtask

    task automatic test_blank();
        logic [15:0] an_exp;
        logic [27:0] seg_exp;
        wait_slot0("blank_sync");
        tick();
        tick();
        blank = 1'b1;
        strobe(12'd42);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (AN !== 4'b1111 || SEG !== 7'b1111111) begin
                errors++;
                $display("FAIL blank_on cyc %0d: AN=%b SEG=%b expected 1111 1111111", i, AN, SEG);
            end
            if (i < 13) tick();
        end
        checks++;
        if (dut.disp_q !== 16'h0042 || busy !== 1'b0) begin
            errors++;
            $display("FAIL blank_commit_42: disp=%h busy=%b expected 0042 0", dut.disp_q, busy);
        end
        blank = 1'b0;
        tick();
        checks++;
        if (AN !== 4'b1110 || SEG !== 7'b0100100) begin
            errors++;
            $display("FAIL unblank_immediate: AN=%b SEG=%b expected 1110 0100100", AN, SEG);
        end
        an_exp  = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
        seg_exp = {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100};
        wait_slot0("frame_42");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (AN !== an_exp[4*k +: 4] || SEG !== seg_exp[7*k +: 7]) begin
                    errors++;
                    $display("FAIL frame_42 slot %0d cyc %0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                             k, j, AN, SEG, an_exp[4*k +: 4], seg_exp[7*k +: 7]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        strobe(12'd999);
        tick();
        strobe(12'd555);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || AN !== 4'b1111 || SEG !== 7'b1111111 || dut.disp_q !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_conv: busy=%b AN=%b SEG=%b disp=%h expected 0 1111 1111111 0000",
                     busy, AN, SEG, dut.disp_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || dut.disp_q !== 16'h0000 || AN[3:1] !== 3'b111) begin
                errors++;
                $display("FAIL after_reset cyc %0d: busy=%b disp=%h AN=%b expected 0 0000 111x",
                         i, busy, dut.disp_q, AN);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan_1234();
        test_lz_blank();
        test_back_to_back();
        test_blank();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_scheduler.md
Name: sevenseg_scan_scheduler

Overview:
Time-multiplexing scheduler for the Basys3 4-digit seven-segment display.
- Accepts a 12-bit binary value with a valid strobe and converts it to BCD sequentially (shift-add-3, one bit per cycle).
- Commits the four BCD digits atomically to a display register, then scans the anodes round-robin with leading-zero blanking.
- Sits between the motor/current measurement logic and the board pins SEG/AN.

Parameters:
- DIGIT_CYCLES, 100000: clk cycles each digit stays lit (1 ms at 100 MHz); must be ≥2.
- WIDTH, 12: binary input width; fixed at 12 for 4 BCD digits (max 4095).
- LZ_BLANK, 1: 1 blanks leading zeros; 0 shows all four digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- value  in  12  unsigned binary value to display.
- value_valid  in  1  one-cycle strobe; value sampled on this edge.
- blank  in  1  level; 1 turns all anodes off.
- busy  out  1  conversion in progress.
- SEG  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- AN  out  4  anodes, active-low, AN[0] = rightmost digit.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - AN=4'b1111, SEG=7'b1111111, busy=0.
  - Display BCD register=0, pending register empty, FSM=IDLE.
  - Scan index=0, refresh counter=0.
- FSM IDLE/CONV/COMMIT:
  - IDLE → CONV on value_valid, or on a non-empty pending register (pending takes priority). Operand is loaded into the shift register; BCD accumulator is cleared.
  - CONV runs exactly 12 cycles. Each cycle: add 3 to every BCD nibble ≥5, then shift left one bit, taking the binary MSB in.
  - After the 12th shift → COMMIT. At the next edge the 16-bit BCD result loads the display register, then → IDLE.
- busy: high from the cycle after acceptance through the COMMIT cycle, i.e. 13 cycles.
- Latency: display register updated 14 edges after the value_valid edge (acceptance edge + 12 CONV edges + 1 COMMIT edge). The new value becomes visible at the next scan slot boundary or on the current slot's next refresh.
- Strobe while busy:
  - value goes into a one-deep pending register; a later strobe overwrites it (latest wins).
  - Pending is converted immediately after COMMIT. No value is ever dropped except one superseded while pending.
  - A strobe in the same cycle IDLE consumes pending: pending goes to conversion, and the new value becomes the new pending.
- Display register changes only at COMMIT; a partial conversion is never visible.
- Scan:
  - Free-running refresh counter, 0..DIGIT_CYCLES-1; at wrap, scan index advances 0→1→2→3→0.
  - AN is the active-low one-hot of the scan index, registered.
  - SEG is the registered decode of the selected nibble, aligned with AN in the same cycle (no ghosting).
  - Scan runs regardless of busy.
- Leading-zero blanking (LZ_BLANK=1): digit k is blanked (AN[k]=1) if it and all higher digits are 0, for k≥1. Digit 0 is always shown, so value 0 displays "0".
- blank=1: AN=4'b1111 from the next edge, SEG=7'b1111111. Scan counter keeps running, and conversion/commit continue unaffected.
- BCD nibbles >9 cannot occur. The decoder maps them to all-off.
- rst mid-conversion: conversion and pending value are discarded, and all state returns to reset values on that edge.

Decomposition:
- Shared package sevenseg_pkg:
  - Active-low segment constants for digits 0–9 and SEG_OFF.
  - AN_OFF, BCD_DIGITS=4, state encodings IDLE/CONV/COMMIT.
- One combinational sub-module, sevenseg_decode: 4-bit BCD → 7-bit active-low SEG, used for the registered SEG output.
- The scheduler holds the FSM, shift-add-3 datapath, pending register and scan counter.

Test Plan:
- All tests use DIGIT_CYCLES=4.
- Reset: assert rst for 2 cycles → AN=1111, SEG=1111111, busy=0. After release, AN=1110 and SEG=1000000 ("0"); AN1–3 never go low.
- Strobe value=1234 → busy high 13 cycles, display register=16'h1234 at edge 14. Over one scan frame: AN 1110/1101/1011/0111 with SEG 0011001("4"), 0110000("3"), 0100100("2"), 1111001("1"), each held 4 cycles.
- value=7, LZ_BLANK=1 → only AN[0] pulses low with SEG=1111000. Then value=4095 → digits 4,0,9,5 all shown; internal 0 is not blanked.
- Back-to-back: strobe 100, then 200 and 300 while busy → display shows 100, then 300; 200 never committed; busy stays high across both conversions with no IDLE gap.
- blank=1 mid-frame → AN=1111 next edge while a concurrent conversion of 42 still commits. blank=0 → "42" shown immediately.
- Assert rst at CONV cycle 6 of value 999 → display register stays at prior value 0, busy=0, no commit follows.
